// File: rtl/dram_rom_ctl_if.sv
// dram_rom_ctl_if
//   Bus-side bundle between the 68k bus decode and dram_rom_ctl.
//   master : bus decode / CPU side. Drives the word address A, the 68k strobes
//            (nWE, nAS, nLDS, nUDS), the CACT qualifier and the region selects
//            (RAMCS, ROMCS). Observes Ready and the refresh status outputs.
//   slave  : controller side. Samples the strobes and returns Ready, RefReq,
//            RefUrgent and RefAck.
//   A layout: column A[RA_W:1], row A[2*RA_W:RA_W+1], bank bits above the row.
interface dram_rom_ctl_if #(
  parameter int RA_W  = 10,
  parameter int BANKS = 2
);
  localparam int BB = $clog2(BANKS);

  logic [2*RA_W+BB:1] A;
  logic               nWE;
  logic               nAS;
  logic               nLDS;
  logic               nUDS;
  logic               CACT;
  logic               RAMCS;
  logic               ROMCS;
  logic               Ready;
  logic               RefReq;
  logic               RefUrgent;
  logic               RefAck;

  modport master (
    output A, nWE, nAS, nLDS, nUDS, CACT, RAMCS, ROMCS,
    input  Ready, RefReq, RefUrgent, RefAck
  );

  modport slave (
    input  A, nWE, nAS, nLDS, nUDS, CACT, RAMCS, ROMCS,
    output Ready, RefReq, RefUrgent, RefAck
  );
endinterface

// File: rtl/dram_rom_ctl.sv
// dram_rom_ctl
//   Memory controller for banked DRAM plus a ROM/flash device, driven from the
//   68k bus strobes. Two independent FSMs: the DRAM machine (accesses and
//   CAS-before-RAS refresh) and the ROM machine, so a refresh can run while a
//   ROM access is in progress. A free-running divider posts refresh ticks into
//   a saturating 2-bit pending counter.
//
// Ports
//   CLK     : sole clock, rising edge
//   RES     : synchronous active-high reset
//   bus     : dram_rom_ctl_if.slave (address, 68k strobes, selects, Ready,
//             RefReq, RefUrgent, RefAck)
//   RA      : multiplexed DRAM address (row, then column)
//   nRAS    : per-bank row strobes, active low
//   nCAS    : column strobe, active low (shared by all banks)
//   nLWE    : DRAM lower-byte write enable, active low
//   nUWE    : DRAM upper-byte write enable, active low
//   nOE     : output enable for DRAM and ROM reads, active low
//   nROMCS  : ROM chip select, active low
//   nROMWE  : ROM write enable, active low
//
// Every output is a flop loaded from the next-state decode, so each output
// changes on the same edge that moves its FSM into the matching state.
module dram_rom_ctl #(
  parameter int RA_W    = 10,
  parameter int BANKS   = 2,
  parameter int TCAS    = 2,
  parameter int TRP     = 2,
  parameter int ROM_WS  = 3,
  parameter int REF_DIV = 128,
  parameter int URG     = 2
) (
  input  logic               CLK,
  input  logic               RES,
  dram_rom_ctl_if.slave      bus,
  output logic [RA_W-1:0]    RA,
  output logic [BANKS-1:0]   nRAS,
  output logic               nCAS,
  output logic               nLWE,
  output logic               nUWE,
  output logic               nOE,
  output logic               nROMCS,
  output logic               nROMWE
);

  localparam int BB = $clog2(BANKS);
  localparam int DW = $clog2(REF_DIV);

  localparam logic [2:0]    TCAS_M1 = 3'(TCAS - 1);
  localparam logic [2:0]    TCAS_C  = 3'(TCAS);
  localparam logic [2:0]    TRP_M1  = 3'(TRP - 1);
  localparam logic [3:0]    ROM_C   = 4'(ROM_WS);
  localparam logic [DW-1:0] DIV_MAX = DW'(REF_DIV - 1);
  localparam logic [1:0]    URG_C   = 2'(URG);

  typedef enum logic [2:0] {
    D_IDLE,
    D_RAS,
    D_COL,
    D_CAS,
    D_HOLD,
    D_PRE,
    D_RCAS,
    D_RRAS
  } d_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_HOLD
  } r_state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  d_state_t          r_d_st;
  r_state_t          r_r_st;
  logic [2:0]        r_dcnt;
  logic [3:0]        r_rcnt;
  logic [BB-1:0]     r_bank;
  logic [DW-1:0]     r_div;
  logic [1:0]        r_pend;
  logic              r_ready;
  logic              r_ref_req;
  logic              r_ref_urgent;
  logic              r_ref_ack;
  logic [RA_W-1:0]   r_ra;
  logic [BANKS-1:0]  r_nras;
  logic              r_ncas;
  logic              r_nlwe;
  logic              r_nuwe;
  logic              r_noe;
  logic              r_nromcs;
  logic              r_nromwe;

  // ---------------------------------------------------------------------------
  // Request decode and address fields
  // ---------------------------------------------------------------------------
  logic              w_ram_req;
  logic              w_rom_req;
  logic [RA_W-1:0]   w_a_col;
  logic [RA_W-1:0]   w_a_row;
  logic [BB-1:0]     w_a_bank;
  logic [BB-1:0]     w_bank_sel;

  assign w_ram_req = !bus.nAS && bus.CACT && bus.RAMCS;
  assign w_rom_req = !bus.nAS && bus.CACT && bus.ROMCS && !bus.RAMCS;
  assign w_a_col   = bus.A[RA_W:1];
  assign w_a_row   = bus.A[2*RA_W:RA_W+1];
  assign w_a_bank  = bus.A[2*RA_W+BB:2*RA_W+1];

  // The bank tracks the bus while idle and freezes once an access starts, so
  // nRAS stays on the same bank even if A moves before nAS is released.
  assign w_bank_sel = (r_d_st == D_IDLE) ? w_a_bank : r_bank;

  // ---------------------------------------------------------------------------
  // DRAM FSM next state
  // ---------------------------------------------------------------------------
  d_state_t          w_d_nxt;
  logic [2:0]        w_dcnt_nxt;
  logic              w_ref_start;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_d_nxt     = r_d_st;
    w_dcnt_nxt  = r_dcnt;
    w_ref_start = 1'b0;
    unique case (r_d_st)
      D_IDLE: begin
        // Urgent refresh beats a waiting access; a non-urgent one only runs
        // when the bus is not asking for DRAM.
        if (r_ref_urgent || (r_ref_req && !w_ram_req)) begin
          w_d_nxt     = D_RCAS;
          w_ref_start = 1'b1;
        end else if (w_ram_req) begin
          w_d_nxt = D_RAS;
        end
      end
      D_RAS: w_d_nxt = D_COL;
      D_COL: begin
        w_d_nxt    = D_CAS;
        w_dcnt_nxt = TCAS_M1;
      end
      D_CAS: begin
        if (r_dcnt == 3'd0) w_d_nxt = D_HOLD;
        else                w_dcnt_nxt = r_dcnt - 3'd1;
      end
      D_HOLD: begin
        if (bus.nAS) begin
          w_d_nxt    = D_PRE;
          w_dcnt_nxt = TRP_M1;
        end
      end
      D_PRE: begin
        if (r_dcnt == 3'd0) w_d_nxt = D_IDLE;
        else                w_dcnt_nxt = r_dcnt - 3'd1;
      end
      D_RCAS: begin
        w_d_nxt    = D_RRAS;
        w_dcnt_nxt = TCAS_C;
      end
      D_RRAS: begin
        if (r_dcnt == 3'd0) begin
          w_d_nxt    = D_PRE;
          w_dcnt_nxt = TRP_M1;
        end else begin
          w_dcnt_nxt = r_dcnt - 3'd1;
        end
      end
      default: w_d_nxt = D_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // DRAM strobes for the state being entered
  // ---------------------------------------------------------------------------
  logic [RA_W-1:0]   w_ra;
  logic [BANKS-1:0]  w_nras;
  logic              w_ncas;
  logic              w_nlwe;
  logic              w_nuwe;
  logic              w_noe_d;

  always_comb begin
    w_ra    = r_ra;
    w_nras  = '1;
    w_ncas  = 1'b1;
    w_nlwe  = 1'b1;
    w_nuwe  = 1'b1;
    w_noe_d = 1'b1;
    unique case (w_d_nxt)
      D_RAS: begin
        w_nras[w_bank_sel] = 1'b0;
        w_ra               = w_a_row;
      end
      D_COL: begin
        w_nras[w_bank_sel] = 1'b0;
        w_ra               = w_a_col;
      end
      D_CAS, D_HOLD: begin
        w_nras[w_bank_sel] = 1'b0;
        w_ncas             = 1'b0;
        if (bus.nWE) begin
          w_noe_d = 1'b0;
        end else begin
          w_nlwe = bus.nLDS;
          w_nuwe = bus.nUDS;
        end
      end
      // CAS-before-RAS refresh: the DRAM's internal counter supplies the row.
      D_RCAS: w_ncas = 1'b0;
      D_RRAS: begin
        w_nras = '0;
        w_ncas = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ROM FSM next state and strobes
  // ---------------------------------------------------------------------------
  r_state_t          w_r_nxt;
  logic [3:0]        w_rcnt_nxt;
  logic              w_nromcs;
  logic              w_nromwe;
  logic              w_noe_r;

  // The counter is loaded with ROM_WS on entry and R_WAIT exits when it reads
  // zero, so the first wait cycle acts as chip-select setup and Ready comes
  // ROM_WS+1 edges after the request is sampled.
  always_comb begin
    w_r_nxt    = r_r_st;
    w_rcnt_nxt = r_rcnt;
    unique case (r_r_st)
      R_IDLE: begin
        if (w_rom_req) begin
          w_r_nxt    = R_WAIT;
          w_rcnt_nxt = ROM_C;
        end
      end
      R_WAIT: begin
        if (r_rcnt == 4'd0) w_r_nxt = R_HOLD;
        else                w_rcnt_nxt = r_rcnt - 4'd1;
      end
      R_HOLD: begin
        if (bus.nAS) w_r_nxt = R_IDLE;
      end
      default: w_r_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_nromcs = 1'b1;
    w_nromwe = 1'b1;
    w_noe_r  = 1'b1;
    if (w_r_nxt != R_IDLE) begin
      w_nromcs = 1'b0;
      if (bus.nWE) w_noe_r  = 1'b0;
      else         w_nromwe = bus.nLDS & bus.nUDS;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh divider and pending counter
  // ---------------------------------------------------------------------------
  logic              w_tick;
  logic [1:0]        w_pend_nxt;

  assign w_tick = (r_div == DIV_MAX);

  always_comb begin
    w_pend_nxt = r_pend;
    unique case ({w_tick, w_ref_start})
      2'b10:   w_pend_nxt = (r_pend == 2'd3) ? 2'd3 : r_pend + 2'd1;
      2'b01:   w_pend_nxt = r_pend - 2'd1;
      default: w_pend_nxt = r_pend;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_d_st       <= D_IDLE;
      r_r_st       <= R_IDLE;
      r_dcnt       <= '0;
      r_rcnt       <= '0;
      r_bank       <= '0;
      r_div        <= '0;
      r_pend       <= '0;
      r_ready      <= 1'b0;
      r_ref_req    <= 1'b0;
      r_ref_urgent <= 1'b0;
      r_ref_ack    <= 1'b0;
      r_ra         <= '0;
      r_nras       <= '1;
      r_ncas       <= 1'b1;
      r_nlwe       <= 1'b1;
      r_nuwe       <= 1'b1;
      r_noe        <= 1'b1;
      r_nromcs     <= 1'b1;
      r_nromwe     <= 1'b1;
    end else begin
      r_d_st       <= w_d_nxt;
      r_r_st       <= w_r_nxt;
      r_dcnt       <= w_dcnt_nxt;
      r_rcnt       <= w_rcnt_nxt;
      r_bank       <= w_bank_sel;
      r_div        <= w_tick ? '0 : r_div + 1'b1;
      r_pend       <= w_pend_nxt;
      r_ready      <= (w_d_nxt == D_HOLD) || (w_r_nxt == R_HOLD);
      r_ref_req    <= (w_pend_nxt != 2'd0);
      r_ref_urgent <= (w_pend_nxt >= URG_C);
      r_ref_ack    <= w_ref_start;
      r_ra         <= w_ra;
      r_nras       <= w_nras;
      r_ncas       <= w_ncas;
      r_nlwe       <= w_nlwe;
      r_nuwe       <= w_nuwe;
      // nOE is shared: either machine's read may pull it low.
      r_noe        <= w_noe_d & w_noe_r;
      r_nromcs     <= w_nromcs;
      r_nromwe     <= w_nromwe;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Ready     = r_ready;
  assign bus.RefReq    = r_ref_req;
  assign bus.RefUrgent = r_ref_urgent;
  assign bus.RefAck    = r_ref_ack;
  assign RA            = r_ra;
  assign nRAS          = r_nras;
  assign nCAS          = r_ncas;
  assign nLWE          = r_nlwe;
  assign nUWE          = r_nuwe;
  assign nOE           = r_noe;
  assign nROMCS        = r_nromcs;
  assign nROMWE        = r_nromwe;

endmodule
